// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the decoded subset: opcodes, funct codes,
// encoder mnemonic codes, loader FSM states and word-format helpers.
package mips_isa_pkg;

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_J     = 6'h02;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Mnemonic codes presented on the load stream; 10..15 are illegal
    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_OR   = 4'd3,
        MN_SLT  = 4'd4,
        MN_LW   = 4'd5,
        MN_SW   = 4'd6,
        MN_BEQ  = 4'd7,
        MN_ADDI = 4'd8,
        MN_J    = 4'd9
    } mnem_e;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // R-type word; shamt is always zero for this subset
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    // I-type word; immediate is passed verbatim
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // J-type word
    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {OPC_J, target};
    endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: mnemonic + operand fields -> 32-bit MIPS word and a
// legality flag. Fields not used by the selected format are ignored.
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  mnem_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic [31:0] word_s;
    logic        legal_s;

    // Select the instruction format and fill in opcode/funct for the mnemonic
    always_comb begin
        word_s  = 32'h0000_0000;
        legal_s = 1'b1;
        case (mnem_i)
            MN_ADD:  word_s = enc_r(rs_i, rt_i, rd_i, FUNCT_ADD);
            MN_SUB:  word_s = enc_r(rs_i, rt_i, rd_i, FUNCT_SUB);
            MN_AND:  word_s = enc_r(rs_i, rt_i, rd_i, FUNCT_AND);
            MN_OR:   word_s = enc_r(rs_i, rt_i, rd_i, FUNCT_OR);
            MN_SLT:  word_s = enc_r(rs_i, rt_i, rd_i, FUNCT_SLT);
            MN_LW:   word_s = enc_i(OPC_LW, rs_i, rt_i, imm_i);
            MN_SW:   word_s = enc_i(OPC_SW, rs_i, rt_i, imm_i);
            MN_BEQ:  word_s = enc_i(OPC_BEQ, rs_i, rt_i, imm_i);
            MN_ADDI: word_s = enc_i(OPC_ADDI, rs_i, rt_i, imm_i);
            MN_J:    word_s = enc_j(target_i);
            default: begin
                word_s  = 32'h0000_0000;
                legal_s = 1'b0;
            end
        endcase
    end

    assign word_o  = word_s;
    assign legal_o = legal_s;

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts instruction fields on a valid/ready stream, encodes
// them and writes one word per accepted instruction into instruction memory.
// The write pointer saturates at the last word; the session then ends as full.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words,
    output logic              done,
    output logic              full,
    output logic              error
);

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic              error_q, error_d;

    logic [31:0]       pack_word_s;
    logic              pack_legal_s;

    mips_instr_pack u_pack (
        .mnem_i   (in_mnem),
        .rs_i     (in_rs),
        .rt_i     (in_rt),
        .rd_i     (in_rd),
        .imm_i    (in_imm),
        .target_i (in_target),
        .word_o   (pack_word_s),
        .legal_o  (pack_legal_s)
    );

    // Next-state, pointer/counter and registered-output computation
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        words_d      = words_q;
        last_d       = last_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        done_d       = done_q;
        full_d       = full_q;
        error_d      = error_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = {ADDR_W{1'b0}};
                    words_d = {(ADDR_W+1){1'b0}};
                    done_d  = 1'b0;
                    full_d  = 1'b0;
                    error_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    if (pack_legal_s) begin
                        state_d      = ST_WRITE;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ptr_q;
                        imem_wdata_d = pack_word_s;
                        last_d       = in_last;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WRITE: begin
                words_d = words_q + (ADDR_W+1)'(1);
                if (last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ptr_d   = (ptr_q == PTR_MAX) ? ptr_q : ptr_q + ADDR_W'(1);
                end else if (ptr_q == PTR_MAX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    full_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                    ptr_d   = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_LOAD);
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= {ADDR_W{1'b0}};
            words_q      <= {(ADDR_W+1){1'b0}};
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= 32'h0000_0000;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            words_q      <= words_d;
            last_q       <= last_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            done_q       <= done_d;
            full_q       <= full_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign words      = words_q;
    assign done       = done_q;
    assign full       = full_q;
    assign error      = error_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: a default-size instance and a
// 4-word instance share stimulus; expected words come from a shift/or model.
module tb_mips_instr_encoder;

    localparam int AW  = 8;
    localparam int AW2 = 2;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_last;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic a_in_ready, a_imem_we, a_done, a_full, a_error;
    logic [AW-1:0] a_imem_addr;
    logic [31:0]   a_imem_wdata;
    logic [AW:0]   a_words;
    logic b_in_ready, b_imem_we, b_done, b_full, b_error;
    logic [AW2-1:0] b_imem_addr;
    logic [31:0]    b_imem_wdata;
    logic [AW2:0]   b_words;

    int checks = 0;
    int errors = 0;

    int          a_wa[$];
    logic [31:0] a_wd[$];
    int          b_wa[$];
    logic [31:0] b_wd[$];

    mips_instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(a_imem_we), .imem_addr(a_imem_addr),
        .imem_wdata(a_imem_wdata), .words(a_words), .done(a_done), .full(a_full), .error(a_error)
    );

    mips_instr_encoder #(.ADDR_W(AW2)) dut_small (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
        .imem_wdata(b_imem_wdata), .words(b_words), .done(b_done), .full(b_full), .error(b_error)
    );

    always #5 clk = ~clk;

    // Memory-side monitor: record every write strobe seen at a clock edge
    always @(posedge clk) begin
        if (!rst && a_imem_we) begin a_wa.push_back(int'(a_imem_addr)); a_wd.push_back(a_imem_wdata); end
        if (!rst && b_imem_we) begin b_wa.push_back(int'(b_imem_addr)); b_wd.push_back(b_imem_wdata); end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference encoder built from the ISA tables with shifts and ors
    function automatic logic [31:0] ref_encode(input int mn, input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [15:0] imm,
                                               input logic [25:0] tgt);
        int functs[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        int ops[4]    = '{32'h23, 32'h2B, 32'h04, 32'h08};
        logic [31:0] w;
        if (mn <= 4)      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(functs[mn]);
        else if (mn <= 8) w = (32'(ops[mn-5]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        else              w = (32'd2 << 26) | 32'(tgt);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_mnem = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0; in_target = 26'd0;
        tick(); tick();
        rst = 1'b0;
        a_wa.delete(); a_wd.delete(); b_wa.delete(); b_wd.delete();
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_fields(input int mn, input int rs, input int rt, input int rd,
                              input int imm, input int tgt, input bit last);
        in_mnem = 4'(mn); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
    endtask

    // Hold in_valid until the selected instance shows in_ready, bounded
    task automatic send(input bit use_b, input int max_cyc, output bit acc);
        acc = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < max_cyc && !acc; i++) begin
            if ((use_b ? b_in_ready : a_in_ready) == 1'b1) acc = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if ({a_in_ready, a_imem_we, a_done, a_full, a_error} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b required 00000", {a_in_ready, a_imem_we, a_done, a_full, a_error}); end
        checks++; if (a_imem_addr !== '0 || a_imem_wdata !== 32'h0 || a_words !== '0) begin errors++; $display("FAIL reset_data: addr %h wdata %h words %0d, required zeros", a_imem_addr, a_imem_wdata, a_words); end
        checks++; if ({b_in_ready, b_imem_we, b_done, b_full, b_error} !== 5'b0) begin errors++; $display("FAIL reset_small: got %b required 00000", {b_in_ready, b_imem_we, b_done, b_full, b_error}); end
        rst = 1'b0;
        tick();
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b required 0", a_in_ready); end
    endtask

    task automatic test_add();
        bit acc;
        do_reset(); do_start();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b required 1", a_in_ready); end
        set_fields(0, 1, 2, 3, 0, 0, 1'b0);
        send(1'b0, 4, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL add_accept: got %b required 1", acc); end
        checks++; if (a_imem_we !== 1'b1 || a_imem_addr !== 8'd0) begin errors++; $display("FAIL add_write: we %b addr %0d, required 1 and 0", a_imem_we, a_imem_addr); end
        checks++; if (a_imem_wdata !== 32'h0022_1820) begin errors++; $display("FAIL add_wdata: got %h required 00221820", a_imem_wdata); end
        tick();
        checks++; if (a_imem_we !== 1'b0 || a_words !== 9'd1 || a_in_ready !== 1'b1) begin errors++; $display("FAIL add_after: we %b words %0d ready %b, required 0 1 1", a_imem_we, a_words, a_in_ready); end
        checks++; if (a_wa.size() != 1) begin errors++; $display("FAIL add_count: got %0d writes required 1", a_wa.size()); end
    endtask

    task automatic test_lw_beq();
        bit acc;
        do_reset(); do_start();
        set_fields(5, 29, 8, 0, 16'h0004, 0, 1'b0);
        send(1'b0, 4, acc);
        set_fields(7, 1, 2, 0, 16'hFFFF, 0, 1'b1);
        send(1'b0, 4, acc);
        tick();
        checks++; if (a_wa.size() != 2) begin errors++; $display("FAIL lwbeq_count: got %0d writes required 2", a_wa.size()); end
        else begin
            checks++; if (a_wa[0] != 0 || a_wd[0] !== 32'h8FA8_0004) begin errors++; $display("FAIL lw_word: addr %0d data %h, required 0 8fa80004", a_wa[0], a_wd[0]); end
            checks++; if (a_wa[1] != 1 || a_wd[1] !== 32'h1022_FFFF) begin errors++; $display("FAIL beq_word: addr %0d data %h, required 1 1022ffff", a_wa[1], a_wd[1]); end
        end
        checks++; if (a_done !== 1'b1 || a_words !== 9'd2) begin errors++; $display("FAIL lwbeq_done: done %b words %0d, required 1 2", a_done, a_words); end
    endtask

    task automatic test_jump_last();
        bit acc;
        do_reset(); do_start();
        set_fields(9, 31, 31, 31, 16'hABCD, 26'h000_0010, 1'b1);
        send(1'b0, 4, acc);
        checks++; if (a_imem_we !== 1'b1 || a_imem_wdata !== 32'h0800_0010) begin errors++; $display("FAIL j_word: we %b data %h, required 1 08000010", a_imem_we, a_imem_wdata); end
        tick();
        checks++; if (a_done !== 1'b1 || a_full !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL j_done: done %b full %b ready %b, required 1 0 0", a_done, a_full, a_in_ready); end
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        checks++; if (a_wa.size() != 1 || a_words !== 9'd1) begin errors++; $display("FAIL j_hold: writes %0d words %0d, required 1 1", a_wa.size(), a_words); end
    endtask

    task automatic test_illegal();
        bit acc;
        do_reset(); do_start();
        set_fields(0, 3, 4, 5, 0, 0, 1'b0);
        send(1'b0, 4, acc);
        set_fields(12, 1, 1, 1, 0, 0, 1'b0);
        send(1'b0, 4, acc);
        checks++; if (acc !== 1'b1 || a_imem_we !== 1'b0 || a_error !== 1'b1) begin errors++; $display("FAIL illegal_flag: acc %b we %b error %b, required 1 0 1", acc, a_imem_we, a_error); end
        tick(); tick(); tick();
        checks++; if (a_words !== 9'd1 || a_in_ready !== 1'b0 || a_wa.size() != 1 || a_error !== 1'b1) begin errors++; $display("FAIL illegal_hold: words %0d ready %b writes %0d error %b, required 1 0 1 1", a_words, a_in_ready, a_wa.size(), a_error); end
        do_start();
        checks++; if (a_error !== 1'b0 || a_in_ready !== 1'b1 || a_words !== 9'd0) begin errors++; $display("FAIL illegal_restart: error %b ready %b words %0d, required 0 1 0", a_error, a_in_ready, a_words); end
        set_fields(3, 7, 8, 9, 0, 0, 1'b1);
        send(1'b0, 4, acc);
        checks++; if (a_imem_we !== 1'b1 || a_imem_addr !== 8'd0 || a_imem_wdata !== ref_encode(3, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0)) begin errors++; $display("FAIL illegal_ptr: we %b addr %0d data %h", a_imem_we, a_imem_addr, a_imem_wdata); end
    endtask

    task automatic test_start_valid_idle();
        do_reset();
        set_fields(0, 1, 2, 3, 0, 0, 1'b0);
        in_valid = 1'b1; start = 1'b1;
        tick();
        in_valid = 1'b0; start = 1'b0;
        checks++; if (a_in_ready !== 1'b1 || a_imem_we !== 1'b0 || a_words !== 9'd0) begin errors++; $display("FAIL idle_start_valid: ready %b we %b words %0d, required 1 0 0", a_in_ready, a_imem_we, a_words); end
        tick();
        checks++; if (a_wa.size() != 0) begin errors++; $display("FAIL idle_start_nowrite: got %0d writes required 0", a_wa.size()); end
    endtask

    task automatic test_small_full();
        bit acc;
        logic [31:0] exp_w[4];
        do_reset(); do_start();
        for (int k = 0; k < 4; k++) begin
            int mn;
            logic [4:0] rs, rt, rd;
            logic [15:0] imm;
            logic [25:0] tgt;
            mn = $urandom_range(0, 9);
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            imm = 16'($urandom); tgt = 26'($urandom);
            exp_w[k] = ref_encode(mn, rs, rt, rd, imm, tgt);
            set_fields(mn, int'(rs), int'(rt), int'(rd), int'(imm), int'(tgt), 1'b0);
            send(1'b1, 4, acc);
            checks++; if (acc !== 1'b1 || b_imem_we !== 1'b1 || int'(b_imem_addr) != k || b_imem_wdata !== exp_w[k]) begin errors++; $display("FAIL small_word%0d: acc %b we %b addr %0d data %h, required 1 1 %0d %h", k, acc, b_imem_we, b_imem_addr, b_imem_wdata, k, exp_w[k]); end
        end
        tick();
        checks++; if (b_done !== 1'b1 || b_full !== 1'b1 || b_words !== 3'd4 || b_in_ready !== 1'b0) begin errors++; $display("FAIL small_full: done %b full %b words %0d ready %b, required 1 1 4 0", b_done, b_full, b_words, b_in_ready); end
        set_fields(0, 1, 1, 1, 0, 0, 1'b0);
        send(1'b1, 6, acc);
        checks++; if (acc !== 1'b0 || b_wa.size() != 4) begin errors++; $display("FAIL small_fifth: accepted %b writes %0d, required 0 4", acc, b_wa.size()); end
        else begin
            checks++; if (b_wa[3] != 3 || b_wd[3] !== exp_w[3]) begin errors++; $display("FAIL small_mem: addr %0d data %h, required 3 %h", b_wa[3], b_wd[3], exp_w[3]); end
        end
    endtask

    task automatic test_random();
        bit acc;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            int n;
            int bad;
            logic [31:0] exp_q[$];
            do_start();
            a_wa.delete(); a_wd.delete();
            n = $urandom_range(5, 20);
            bad = 0;
            for (int i = 0; i < n; i++) begin
                int mn;
                logic [4:0] rs, rt, rd;
                logic [15:0] imm;
                logic [25:0] tgt;
                mn = $urandom_range(0, 9);
                rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
                imm = 16'($urandom); tgt = 26'($urandom);
                exp_q.push_back(ref_encode(mn, rs, rt, rd, imm, tgt));
                set_fields(mn, int'(rs), int'(rt), int'(rd), int'(imm), int'(tgt), (i == n - 1));
                start = (i != n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                send(1'b0, 4, acc);
                start = 1'b0;
                if (acc !== 1'b1 || a_imem_we !== 1'b1 || int'(a_imem_addr) != i || a_imem_wdata !== exp_q[i]) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_stream%0d: %0d of %0d words wrong", s, bad, n); end
            tick();
            checks++; if (a_done !== 1'b1 || a_full !== 1'b0 || int'(a_words) != n) begin errors++; $display("FAIL rand_done%0d: done %b full %b words %0d, required 1 0 %0d", s, a_done, a_full, a_words, n); end
            bad = (a_wa.size() != n) ? 1 : 0;
            for (int i = 0; i < a_wa.size() && i < n; i++) if (a_wa[i] != i || a_wd[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_mem%0d: %0d discrepancies, %0d writes for %0d words", s, bad, a_wa.size(), n); end
        end
    endtask

    task automatic test_reset_mid_write();
        bit acc;
        do_reset(); do_start();
        set_fields(0, 1, 2, 3, 0, 0, 1'b0);
        send(1'b0, 4, acc);
        checks++; if (a_imem_we !== 1'b1) begin errors++; $display("FAIL midrst_pre: we %b required 1", a_imem_we); end
        rst = 1'b1;
        #1;
        checks++; if ({a_in_ready, a_imem_we, a_done, a_full, a_error} !== 5'b0 || a_imem_addr !== '0 || a_imem_wdata !== 32'h0 || a_words !== '0) begin errors++; $display("FAIL midrst_clear: flags %b addr %0d data %h words %0d, required zeros", {a_in_ready, a_imem_we, a_done, a_full, a_error}, a_imem_addr, a_imem_wdata, a_words); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (a_wa.size() != 0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_idle: writes %0d ready %b, required 0 0", a_wa.size(), a_in_ready); end
        do_start();
        set_fields(1, 4, 5, 6, 0, 0, 1'b1);
        send(1'b0, 4, acc);
        checks++; if (a_imem_we !== 1'b1 || a_imem_addr !== 8'd0 || a_imem_wdata !== ref_encode(1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0)) begin errors++; $display("FAIL midrst_recover: we %b addr %0d data %h", a_imem_we, a_imem_addr, a_imem_wdata); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_beq();
        test_jump_last();
        test_illegal();
        test_start_valid_idle();
        test_small_full();
        test_random();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
